// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the execute-stage
// multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam logic [4:0] ADD_CONTROL   = 5'b00010;
    localparam logic [4:0] MULT_CONTROL  = 5'b11000;
    localparam logic [4:0] MULTU_CONTROL = 5'b11001;
    localparam logic [4:0] DIV_CONTROL   = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

    localparam int MUL_LAT_DEF  = 1;
    localparam int DIV_ITER_DEF = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL) ||
               (code == DIV_CONTROL)  || (code == DIVU_CONTROL);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Iterative restoring unsigned divider: one quotient bit per step, MSB first.
// The quotient/remainder outputs show the result of the step being taken now.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quotient  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign done      = step && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for MULT/MULTU/DIV/DIVU: stalls the pipe while busy,
// then issues a one-cycle {HI,LO} write.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  alu_controlE,
    input  logic        flushE,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_o
);

    md_state_t   state;
    md_state_t   state_nxt;
    logic [2:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_signed;
    logic        neg_q;
    logic        neg_r;

    logic        start;
    logic        op_div;
    logic        op_signed;
    logic        core_start;
    logic        core_step;
    logic        core_done;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign op_div    = (alu_controlE == DIV_CONTROL)  || (alu_controlE == DIVU_CONTROL);
    assign op_signed = (alu_controlE == MULT_CONTROL) || (alu_controlE == DIV_CONTROL);
    assign start     = (state == MD_IDLE) && is_muldiv(alu_controlE) && !flushE;

    assign mul_a   = is_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
    assign mul_b   = is_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
    assign product = mul_a * mul_b;

    assign quo_fix = magnitude(core_quo, neg_q);
    assign rem_fix = magnitude(core_rem, neg_r);

    div_radix2_core #(
        .WIDTH(DIV_ITER)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .step     (core_step),
        .flush    (flushE),
        .dividend (magnitude(a, op_signed && a[31])),
        .divisor  (magnitude(b, op_signed && b[31])),
        .done     (core_done),
        .quotient (core_quo),
        .remainder(core_rem)
    );

    always_comb begin
        state_nxt  = state;
        stall_o    = 1'b0;
        core_start = 1'b0;
        core_step  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    stall_o    = 1'b1;
                    core_start = op_div;
                    state_nxt  = op_div ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL: begin
                stall_o = 1'b1;
                if (cnt == 3'(MUL_LAT - 1)) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DIV: begin
                stall_o   = 1'b1;
                core_step = 1'b1;
                if (core_done) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
        if (flushE && state != MD_IDLE) begin
            state_nxt = MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hilo_we_o <= 1'b0;
            hilo_o    <= '0;
        end else begin
            state     <= state_nxt;
            hilo_we_o <= (state_nxt == MD_DONE);
            cnt       <= (state == MD_MUL && state_nxt == MD_MUL) ? cnt + 3'd1 : 3'd0;
            if (start) begin
                op_a      <= a;
                op_b      <= b;
                is_signed <= op_signed;
                // A zero divisor counts as positive, which gives 1 for a negative dividend.
                neg_q     <= op_signed && (a[31] ^ b[31]);
                neg_r     <= op_signed && a[31];
            end
            if (state_nxt == MD_DONE) begin
                hilo_o <= (state == MD_DIV) ? {rem_fix, quo_fix} : product;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: a driver issues operations and queues the
// arithmetic result; a monitor compares every HI/LO write against the queue.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MUL_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_controlE;
    logic        flushE;
    logic        stall_o;
    logic        hilo_we_o;
    logic [63:0] hilo_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_hilo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_ITER(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .alu_controlE(alu_controlE),
        .flushE      (flushE),
        .stall_o     (stall_o),
        .hilo_we_o   (hilo_we_o),
        .hilo_o      (hilo_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result straight from the arithmetic definition of each instruction.
    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (op)
            MULT_CONTROL:  p = 64'(sx * sy);
            MULTU_CONTROL: p = {32'b0, x} * {32'b0, y};
            DIVU_CONTROL: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else        p = {x % y, x / y};
            end
            DIV_CONTROL: begin
                if (y == 0) begin
                    p = {x, (sx < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (hilo_we_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %h expected no write", hilo_o);
                end else begin
                    check("hilo_write", hilo_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int n;
        int exp_n;
        logic [63:0] res;
        exp_n = (op == DIV_CONTROL || op == DIVU_CONTROL) ? 1 + DIV_ITER_DEF : 1 + MUL_LAT;
        res   = ref_model(op, x, y);
        exp_q.push_back(res);
        last_hilo = res;
        @(negedge clk);
        alu_controlE = op;
        a = x;
        b = y;
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            #1;
        end
        alu_controlE = ADD_CONTROL;
        check("stall_cycles", 64'(n), 64'(exp_n));
        check("we_in_done", 64'(hilo_we_o), 64'd1);
        @(negedge clk);
        #1;
        check("no_restart_stall", 64'(stall_o), 64'd0);
        check("single_pulse", 64'(hilo_we_o), 64'd0);
    endtask

    task automatic flush_after(input logic [4:0] op, input int cyc);
        @(negedge clk);
        alu_controlE = op;
        a = $urandom;
        b = $urandom;
        repeat (cyc - 1) @(negedge clk);
        flushE = 1'b1;
        #1;
        check("stall_before_flush", 64'(stall_o), 64'd1);
        @(negedge clk);
        flushE = 1'b0;
        alu_controlE = ADD_CONTROL;
        #1;
        check("stall_after_flush", 64'(stall_o), 64'd0);
        repeat (40) @(negedge clk);
        check("hilo_hold_after_flush", hilo_o, last_hilo);
    endtask

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
    logic [4:0]  ops      [4] = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};

    initial begin
        rst = 1'b1;
        flushE = 1'b0;
        alu_controlE = ADD_CONTROL;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_hilo", hilo_o, 64'h0);
        check("reset_we", 64'(hilo_we_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;

        run_op(MULT_CONTROL,  32'hFFFF_FFFE, 32'h0000_0003);
        run_op(MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(DIV_CONTROL,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op(DIV_CONTROL,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(DIVU_CONTROL,  32'd100,       32'd7);
        run_op(DIVU_CONTROL,  32'd5,         32'd0);
        run_op(DIV_CONTROL,   32'hFFFF_FFF0, 32'd0);
        run_op(DIV_CONTROL,   32'd9,         32'd0);

        flush_after(DIVU_CONTROL, 10);
        run_op(MULT_CONTROL, 32'h0001_2345, 32'hFFFF_0002);
        flush_after(MULT_CONTROL, 2);

        @(negedge clk);
        alu_controlE = MULT_CONTROL;
        flushE = 1'b1;
        #1;
        check("flush_idle_no_start", 64'(stall_o), 64'd0);
        @(negedge clk);
        flushE = 1'b0;
        alu_controlE = ADD_CONTROL;
        #1;
        check("flush_idle_stall", 64'(stall_o), 64'd0);
        check("add_no_stall", 64'(stall_o), 64'd0);
        repeat (3) @(negedge clk);

        @(negedge clk);
        alu_controlE = DIV_CONTROL;
        a = 32'd1000;
        b = 32'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        alu_controlE = ADD_CONTROL;
        @(negedge clk);
        rst = 1'b0;
        #1;
        last_hilo = '0;
        check("rst_mid_div_stall", 64'(stall_o), 64'd0);
        check("rst_mid_div_hilo", hilo_o, 64'h0);
        check("rst_mid_div_we", 64'(hilo_we_o), 64'd0);
        repeat (40) @(negedge clk);
        check("rst_hilo_hold", hilo_o, 64'h0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
            run_op(ops[$urandom_range(0, 3)], x, y);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_hilo", hilo_o, last_hilo);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for MULT/MULTU/DIV/DIVU. The ALU returns 0 for these four opcodes; this block computes them instead.
- It decodes the same alu_controlE code the ALU receives, latches the operands and runs either a registered multiply or a 32-iteration radix-2 restoring divide.
- It holds the pipeline stalled while busy, then issues a single-cycle {HI,LO} write toward the HI/LO register.

Parameters:
- MUL_LAT, 1, cycles spent in MUL state (1..4).
- DIV_ITER, 32, divide iterations; fixed equal to operand width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  32  rs operand (dividend / multiplicand).
- b  in  32  rt operand (divisor / multiplier).
- alu_controlE  in  5  ALU control code; `MULT_CONTROL, `MULTU_CONTROL, `DIV_CONTROL and `DIVU_CONTROL start an operation.
- flushE  in  1  cancel any in-flight operation (exception/branch flush of E).
- stall_o  out  1  pipeline stall request, combinational.
- hilo_we_o  out  1  HI/LO write enable, registered, one-cycle pulse.
- hilo_o  out  64  {HI,LO} result, registered.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). On rst: state=IDLE, counter=0, hilo_o=0, hilo_we_o=0, internal operand/remainder registers=0.
- States: IDLE, MUL, DIV, DONE.
- start = (state==IDLE) && alu_controlE is one of the four muldiv codes && !flushE.
- stall_o = start || state==MUL || state==DIV. stall_o is 0 in DONE, so E advances at the end of DONE and the same instruction cannot restart.
- Transition IDLE->MUL/DIV on start:
  - latch a, b and the signed flag; clear the counter.
  - Any other alu_controlE value leaves the block in IDLE with no effect.
- MUL:
  - product is computed from the latched operands: signed 32x32->64 for MULT, unsigned for MULTU.
  - after MUL_LAT cycles, register product into hilo_o and go to DONE.
  - Total stall = 1+MUL_LAT cycles.
- DIV:
  - operands are converted to magnitudes if signed; one quotient bit is produced per cycle, MSB first.
  - after DIV_ITER cycles, fix signs and register {HI=remainder, LO=quotient} into hilo_o; go to DONE.
  - Total stall = 33 cycles.
- Sign rules:
  - quotient is negative iff operand signs differ (and divisor is nonzero).
  - remainder takes the sign of the dividend.
  - -2^31 / -1 -> LO=0x80000000, HI=0.
- Divide by zero is not trapped. DIVU x/0 -> LO=0xFFFFFFFF, HI=x. DIV x/0 -> LO=0xFFFFFFFF if x>=0 else 0x00000001, HI=x. The block still takes the full 33 cycles.
- DONE: hilo_we_o=1 for exactly this cycle; next state is IDLE unconditionally.
- hilo_o holds its last value when not being written.
- flushE priority:
  - flushE in MUL, DIV or DONE forces IDLE next cycle and clears the counter.
  - hilo_we_o is 0 in that cycle if flushE coincides with the DONE-producing edge, i.e. no write is issued after a flush.
  - flushE in IDLE suppresses start.
- rst mid-operation behaves like flush and also zeroes hilo_o.
- Operand inputs are ignored outside the IDLE->start cycle.

Decomposition:
- Shared include defines2.vh already holds the ALU control codes and `ZeroWord. Add these there:
  - state encodings MD_IDLE, MD_MUL, MD_DIV, MD_DONE;
  - `DIV_ITER` default.
- One natural sub-module: div_radix2_core. It holds the iterative restoring unsigned divider with start/step/done, 32-bit quotient and remainder, and a counter. muldiv_ctrl owns the sign handling, the multiplier, the FSM and the outputs.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003 -> stall_o high 2 cycles; next cycle hilo_we_o=1, hilo_o=0xFFFFFFFF_FFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hilo_o=0xFFFFFFFE_00000001, one hilo_we_o pulse, no restart after DONE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall_o high exactly 33 cycles; hilo_o=0xFFFFFFFF_FFFFFFFD. DIV 0x80000000/0xFFFFFFFF -> hilo_o=0x00000000_80000000.
- DIVU a=100, b=7 -> hilo_o=0x00000002_0000000E. DIVU a=5, b=0 -> hilo_o=0x00000005_FFFFFFFF.
- DIVU in flight: flushE on cycle 10 -> stall_o low the following cycle, no hilo_we_o pulse, hilo_o unchanged. A new MULT issued right after completes normally.
- rst asserted mid-DIV -> next cycle state IDLE, stall_o=0, hilo_o=0. A non-muldiv code such as `ADD_CONTROL in IDLE -> stall_o=0 and no write.
